puf_result_unloader: RTL and testbench
======================================

Name: puf_result_unloader

Overview:
- Downstream stage of the PUF test FSM.
- After the test FSM raises test_done, this block reads the N_RESULTS per-test pass counts from the shared result memory (8-bit words at BASE_ADDR..BASE_ADDR+N_RESULTS-1).
- It streams them as a framed byte sequence over a valid/ready interface to the SIRC host handler, which forwards them to the PC.

Parameters:
- ADDR_WIDTH, 13, result memory address width.
- DATA_WIDTH, 8, result word and stream byte width.
- N_RESULTS, 8, number of result words per frame (1..255).
- BASE_ADDR, 1, address of the first result word.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk_1  in  1  clock, shared with the test FSM.
- rst  in  1  reset.
- test_done  in  1  level from the test FSM; a rising edge requests one frame.
- mem_raddr  out  ADDR_WIDTH  result memory read address.
- mem_dout  in  DATA_WIDTH  read data, synchronous memory, valid 1 cycle after mem_raddr.
- tx_data  out  DATA_WIDTH  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk_1.
- Reset values: mem_raddr=BASE_ADDR, tx_data=0, tx_valid=0, busy=0, frame_done=0, internal done_q=0, idx=0, checksum=0, state=IDLE.
- Edge detect: done_q <= test_done each cycle; start = test_done & ~done_q.
- Start is honoured only in IDLE. A rising edge while busy is dropped. test_done held high produces exactly one frame.
- A transfer occurs on a posedge where tx_valid & tx_ready. While tx_valid=1 and tx_ready=0, tx_data stays stable and tx_valid never drops.
- FSM states: IDLE, HDR, RD, WAIT, SEND, CKSUM, FIN.
- IDLE: on start -> HDR, busy<=1, idx<=0, checksum<=0, tx_data<=HEADER_BYTE, tx_valid<=1. The header is visible the cycle after start is sampled.
- HDR: on transfer -> RD, tx_valid<=0.
- RD: mem_raddr<=BASE_ADDR+idx (width ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH) -> WAIT.
- WAIT: one cycle for read latency -> SEND, capturing tx_data<=mem_dout, tx_valid<=1, checksum<=checksum^mem_dout.
- SEND: on transfer, idx<=idx+1, tx_valid<=0.
  - If idx==N_RESULTS-1 -> CKSUM (feature on) or FIN (feature off).
  - Otherwise -> RD.
- Minimum spacing between result bytes with tx_ready=1 is 3 cycles.
- CKSUM: tx_data<=checksum, tx_valid<=1; on transfer -> FIN.
- FIN: frame_done<=1 for exactly one cycle, busy<=0, tx_valid<=0 -> IDLE.
- rst mid-frame: all outputs return to reset values on that edge and the partial frame is abandoned. After rst, done_q=0, so a test_done that is still high at release is seen as a rising edge and starts a new frame.
- tx_ready is ignored when tx_valid=0.

Optional Feature:
- Macro: PUF_RESULT_CHECKSUM_EN.
- Defined: frame = HEADER_BYTE, N_RESULTS data bytes, then one XOR checksum byte (XOR of the data bytes only). Length N_RESULTS+2.
- Undefined: CKSUM state and checksum register are absent. Frame = header plus data, length N_RESULTS+1. SEND goes straight to FIN after the last byte.

Decomposition:
- Shared package puf_result_pkg holds:
  - the state encoding (3-bit typedef);
  - HEADER_BYTE default;
  - RESULT_ADDR_WIDTH=13 and N_TESTS=8, shared with the test FSM so memory layout stays consistent.
- Sub-module rise_detect (1-bit registered edge detector, sync reset) is natural and reused by the host handler. Everything else stays flat.

Test Plan:
- Memory [1..8]=8'd250,255,0,17,200,3,128,64; pulse test_done; tx_ready=1.
  - Bytes A5,FA,FF,00,11,C8,03,80,40, then checksum (macro on).
  - frame_done pulses once, busy low afterwards.
- Same memory, tx_ready toggled 1-in-3 cycles: identical byte sequence; tx_data stable whenever tx_valid&~tx_ready; no byte lost or duplicated.
- test_done held high for 200 cycles: exactly one frame. Drop and re-raise test_done: a second identical frame.
- Assert rst during the 4th data byte while tx_ready=0: next cycle tx_valid=0, busy=0, mem_raddr=1. With test_done low at rst release, no new frame until a fresh rising edge.
- Rising edge of test_done mid-frame: ignored; frame completes with 10 bytes (macro on) and no second frame follows.
- Macro off, same memory: exactly 9 bytes; frame_done one cycle after the 40 transfer.

Source files
------------

// File: rtl/puf_result_pkg.sv
// Shared layout constants and unloader state encoding for the PUF
// test FSM, result unloader and host handler.
package puf_result_pkg;

    localparam int RESULT_ADDR_WIDTH = 13;
    localparam int N_TESTS = 8;

    localparam logic [7:0] PUF_HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        WAIT,
        SEND,
        CKSUM,
        FIN
    } unload_state_t;

endpackage

// File: rtl/puf_result_unloader_rise_detect.sv
// Registered rising-edge detector with synchronous active-high reset.
// After reset the history bit is 0, so a level already high reads as an edge.
module rise_detect (
    input  logic clk_1,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk_1) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/puf_result_unloader.sv
// Streams the PUF per-test pass counts as a framed byte sequence.
// Define PUF_RESULT_CHECKSUM_EN to append an XOR checksum byte to each frame.
module puf_result_unloader
    import puf_result_pkg::*;
#(
    parameter int ADDR_WIDTH = RESULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int N_RESULTS = N_TESTS,
    parameter int BASE_ADDR = 1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = PUF_HEADER_BYTE
) (
    input  logic                  clk_1,
    input  logic                  rst,
    input  logic                  test_done,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [7:0] LAST_IDX = 8'(N_RESULTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    unload_state_t state;
    logic [7:0] idx;
    logic start;
    logic xfer;

`ifdef PUF_RESULT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    rise_detect u_rise (
        .clk_1(clk_1),
        .rst  (rst),
        .d    (test_done),
        .rise (start)
    );

    assign xfer = tx_valid & tx_ready;

    // The read address is issued on the way into RD, so the synchronous
    // memory has its data ready by the end of WAIT.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state      <= IDLE;
            mem_raddr  <= BASE;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            idx        <= '0;
`ifdef PUF_RESULT_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        busy     <= 1'b1;
                        idx      <= '0;
                        tx_data  <= HEADER_BYTE;
                        tx_valid <= 1'b1;
`ifdef PUF_RESULT_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        tx_valid  <= 1'b0;
                        mem_raddr <= BASE + ADDR_WIDTH'(idx);
                        state     <= RD;
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    tx_data  <= mem_dout;
                    tx_valid <= 1'b1;
`ifdef PUF_RESULT_CHECKSUM_EN
                    checksum <= checksum ^ mem_dout;
`endif
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        idx      <= idx + 8'd1;
                        if (idx == LAST_IDX) begin
`ifdef PUF_RESULT_CHECKSUM_EN
                            state <= CKSUM;
`else
                            state <= FIN;
`endif
                        end else begin
                            mem_raddr <= BASE + ADDR_WIDTH'(idx)
                                       + ADDR_WIDTH'(1);
                            state     <= RD;
                        end
                    end
                end
                CKSUM: begin
`ifdef PUF_RESULT_CHECKSUM_EN
                    if (!tx_valid) begin
                        tx_data  <= checksum;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= FIN;
                    end
`else
                    state <= FIN;
`endif
                end
                FIN: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    tx_valid   <= 1'b0;
                    mem_raddr  <= BASE;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_result_unloader.sv
// Directed self-checking bench for puf_result_unloader.
module tb_puf_result_unloader;

`ifdef PUF_RESULT_CHECKSUM_EN
    localparam int LEN = 10;
`else
    localparam int LEN = 9;
`endif

    logic        clk_1 = 1'b0;
    logic        rst;
    logic        test_done;
    logic [12:0] mem_raddr;
    logic [7:0]  mem_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    always #5 clk_1 = ~clk_1;

    puf_result_unloader dut (
        .clk_1     (clk_1),
        .rst       (rst),
        .test_done (test_done),
        .mem_raddr (mem_raddr),
        .mem_dout  (mem_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    logic [7:0] mem [0:8191];
    always @(posedge clk_1) mem_dout <= mem[mem_raddr];

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] rx [$];
    int fd_cnt = 0;
    int stab_err = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int fd_cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk_1) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data))
                stab_err <= stab_err + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_data <= tx_data;
            if (tx_valid && tx_ready) begin
                rx.push_back(tx_data);
                last_xfer_cyc <= cyc;
            end
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
        end
    end

    // 0: always ready, 1: ready one cycle in three, 2: never ready
    int rdy_mode = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_1);
            #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    logic [7:0] exp_b [10];

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1);
    endtask

    task automatic pulse_done();
        test_done = 1'b1;
        tick(1);
        test_done = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int limit,
                           input string tag);
        int k = 0;
        while (fd_cnt < target && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, 32'(fd_cnt >= target), 1);
    endtask

    task automatic check_frame(input int base, input string tag);
        check({tag, "_len"}, rx.size() - base, LEN);
        for (int i = 0; i < LEN; i++)
            if (base + i < rx.size())
                check($sformatf("%s_b%0d", tag, i), rx[base + i], exp_b[i]);
    endtask

    int base;
    int f0;
    int k;

    initial begin
        exp_b = '{8'hA5, 8'hFA, 8'hFF, 8'h00, 8'h11,
                  8'hC8, 8'h03, 8'h80, 8'h40, 8'h1F};
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[1] = 8'd250; mem[2] = 8'd255; mem[3] = 8'd0;  mem[4] = 8'd17;
        mem[5] = 8'd200; mem[6] = 8'd3;   mem[7] = 8'd128; mem[8] = 8'd64;

        rst = 1'b1;
        test_done = 1'b0;
        tick(3);
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_raddr", mem_raddr, 1);
        check("rst_data", tx_data, 0);
        rst = 1'b0;
        tick(2);

        // single pulse, sink always ready
        base = rx.size();
        f0 = fd_cnt;
        test_done = 1'b1;
        tick(1);
        check("hdr_valid", tx_valid, 1);
        check("hdr_data", tx_data, 8'hA5);
        check("hdr_busy", busy, 1);
        test_done = 1'b0;
        wait_fd(f0 + 1, 200, "t1_done");
        tick(1);
        check_frame(base, "t1");
        check("t1_fd_cnt", fd_cnt - f0, 1);
        check("t1_busy", busy, 0);
        check("t1_fd_lag", fd_cyc - last_xfer_cyc, 2);

        // back-pressure one cycle in three
        rdy_mode = 1;
        base = rx.size();
        f0 = fd_cnt;
        pulse_done();
        wait_fd(f0 + 1, 400, "t2_done");
        tick(2);
        check_frame(base, "t2");
        check("t2_fd_cnt", fd_cnt - f0, 1);
        check("t2_stable", stab_err, 0);
        rdy_mode = 0;
        tick(2);

        // level held high yields one frame, re-raise yields another
        base = rx.size();
        f0 = fd_cnt;
        test_done = 1'b1;
        tick(200);
        check("t3_one", fd_cnt - f0, 1);
        check_frame(base, "t3a");
        test_done = 1'b0;
        tick(5);
        base = rx.size();
        test_done = 1'b1;
        wait_fd(f0 + 2, 200, "t3_second");
        tick(2);
        check_frame(base, "t3b");
        test_done = 1'b0;
        tick(3);

        // reset while 4th data byte is stalled
        base = rx.size();
        f0 = fd_cnt;
        pulse_done();
        k = 0;
        while (rx.size() - base < 4 && k < 100) begin
            tick(1);
            k++;
        end
        check("t4_reach", 32'(rx.size() - base >= 4), 1);
        rdy_mode = 2;
        k = 0;
        tick(1);
        while (!tx_valid && k < 20) begin
            tick(1);
            k++;
        end
        check("t4_stall_valid", tx_valid, 1);
        check("t4_stall_data", tx_data, exp_b[4]);
        rst = 1'b1;
        tick(1);
        check("t4_valid", tx_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_raddr", mem_raddr, 1);
        check("t4_data", tx_data, 0);
        rst = 1'b0;
        rdy_mode = 0;
        tick(30);
        check("t4_idle", busy, 0);
        check("t4_no_fd", fd_cnt - f0, 0);
        check("t4_no_bytes", rx.size() - base, 4);

        // rising edge mid-frame is dropped
        base = rx.size();
        f0 = fd_cnt;
        pulse_done();
        k = 0;
        while (rx.size() - base < 3 && k < 100) begin
            tick(1);
            k++;
        end
        pulse_done();
        wait_fd(f0 + 1, 200, "t5_done");
        tick(60);
        check("t5_fd_cnt", fd_cnt - f0, 1);
        check_frame(base, "t5");
        check("t5_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
